uart_tx: RTL and testbench

- Serial UART transmitter and companion to uart_rx.
- Accepts bytes on an AXI-stream style slave handshake and serialises them on tx: LSB first, idle high, 1 start bit, 8 data bits, optional parity, 1 or 2 stop bits.
- A one-entry holding register lets the next byte be accepted while the current frame is on the line, so frames go out back-to-back with no idle gap.
- Sits between system logic and the board UART pin; loops back directly into uart_rx in benches.

---
 rtl/uart_tx.sv | 177 +++++++++++++++++
 tb/tb_uart_tx.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx - serial UART transmitter (8 data bits, LSB first, idle-high line).
//
// Frame: 1 start bit, 8 data bits, optional parity bit, 1 or 2 stop bits.
// A one-entry holding register lets the next byte be accepted while the
// current frame is still on the line. This allows frames to go out
// back-to-back without an idle gap.
//
// Parameters:
//   cycles_per_bit  clk cycles per bit period (>= 2)
//   parity_mode     0 = none, 1 = even, 2 = odd
//   stop_bits       1 or 2
//
// Ports:
//   clk     system clock, all logic on the rising edge
//   rst     synchronous active-high reset
//   tvalid  byte on tdata is valid
//   tready  block can accept a byte this cycle
//   tdata   byte to transmit
//   tx      registered serial line, idle high
//   busy    a frame is in progress or a byte is held
module uart_tx #(
   parameter int cycles_per_bit = 434,
   parameter int parity_mode    = 0,
   parameter int stop_bits      = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tvalid,
   output logic       tready,
   input  logic [7:0] tdata,
   output logic       tx,
   output logic       busy
);

   localparam int              CNT_W      = $clog2(cycles_per_bit);
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(cycles_per_bit - 1);
   localparam logic [2:0]      LAST_STOP  = 3'(stop_bits - 1);
   localparam logic            PARITY_INV = (parity_mode == 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [2:0]       bit_reg, bit_next;
   logic [7:0]       shift_reg, shift_next;
   logic             par_reg, par_next;
   logic [7:0]       hold_data_reg, hold_data_next;
   logic             hold_full_reg, hold_full_next;
   logic             tx_reg, tx_next;

   logic xfer;
   logic move;
   logic bit_done;

   assign tready = !rst && !hold_full_reg;
   assign busy   = (state_reg != S_IDLE) || hold_full_reg;
   assign tx     = tx_reg;
   assign xfer   = tvalid && tready;

   // The down-counter hits zero on the last cycle of every bit, so each bit
   // is exactly cycles_per_bit cycles long with no drift between bits.
   assign bit_done = (cnt_reg == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= S_IDLE;
         cnt_reg       <= '0;
         bit_reg       <= '0;
         shift_reg     <= '0;
         par_reg       <= 1'b0;
         hold_data_reg <= '0;
         hold_full_reg <= 1'b0;
         tx_reg        <= 1'b1;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         bit_reg       <= bit_next;
         shift_reg     <= shift_next;
         par_reg       <= par_next;
         hold_data_reg <= hold_data_next;
         hold_full_reg <= hold_full_next;
         tx_reg        <= tx_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      cnt_next       = bit_done ? CNT_RELOAD : cnt_reg - CNT_W'(1);
      bit_next       = bit_reg;
      shift_next     = shift_reg;
      par_next       = par_reg;
      hold_data_next = hold_data_reg;
      hold_full_next = hold_full_reg;
      tx_next        = 1'b1;
      move           = 1'b0;

      // tx_next is derived from the current state, so the line lags the
      // state register by one cycle uniformly for every bit.
      case (state_reg)
         S_IDLE: begin
            tx_next  = 1'b1;
            cnt_next = CNT_RELOAD;
            if (hold_full_reg) begin
               move       = 1'b1;
               state_next = S_START;
            end
         end
         S_START: begin
            tx_next = 1'b0;
            if (bit_done) begin
               state_next = S_DATA;
               bit_next   = '0;
            end
         end
         S_DATA: begin
            tx_next = shift_reg[0];
            if (bit_done) begin
               shift_next = {1'b0, shift_reg[7:1]};
               if (bit_reg == 3'd7) begin
                  bit_next   = '0;
                  state_next = (parity_mode != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_next = bit_reg + 3'd1;
               end
            end
         end
         S_PARITY: begin
            tx_next = par_reg;
            if (bit_done) begin
               state_next = S_STOP;
               bit_next   = '0;
            end
         end
         S_STOP: begin
            tx_next = 1'b1;
            if (bit_done) begin
               if (bit_reg == LAST_STOP) begin
                  bit_next = '0;
                  if (hold_full_reg) begin
                     // Next byte is already waiting: start it immediately.
                     move       = 1'b1;
                     state_next = S_START;
                  end else begin
                     state_next = S_IDLE;
                  end
               end else begin
                  bit_next = bit_reg + 3'd1;
               end
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase

      // Parity is computed once from the whole byte at load time, because
      // the shift register no longer holds the data by the time the parity
      // bit goes out.
      if (move) begin
         shift_next     = hold_data_reg;
         par_next       = (^hold_data_reg) ^ PARITY_INV;
         hold_full_next = 1'b0;
      end

      if (xfer) begin
         hold_data_next = tdata;
         hold_full_next = 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx - self-checking bench for uart_tx.
//
// Four instances cover different parameter sets:
//   0: 434 cycles/bit, no parity, 1 stop bit
//   1: 16 cycles/bit, even parity, 2 stop bits
//   2: 7 cycles/bit, odd parity, 1 stop bit
//   3: 2 cycles/bit, no parity, 2 stop bits
//
// The expected line waveform for each byte is built as a list of frame bits
// from the framing rules. Every cycle of every bit is then compared with the
// expected level.
module tb_uart_tx;

   localparam int NDUT = 4;
   localparam int CPB  [NDUT] = '{434, 16, 7, 2};
   localparam int PAR  [NDUT] = '{0, 1, 2, 0};
   localparam int STOP [NDUT] = '{1, 2, 1, 2};

   logic             clk = 1'b0;
   logic             rst;
   logic [NDUT-1:0]  vld;
   logic [NDUT-1:0]  rdy;
   logic [NDUT-1:0]  tx_line;
   logic [NDUT-1:0]  bsy;
   logic [7:0]       dat [NDUT];

   logic [7:0]       stim [8];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   genvar gi;
   generate
      for (gi = 0; gi < NDUT; gi++) begin : g_dut
         uart_tx #(
            .cycles_per_bit(CPB[gi]),
            .parity_mode   (PAR[gi]),
            .stop_bits     (STOP[gi])
         ) u_dut (
            .clk   (clk),
            .rst   (rst),
            .tvalid(vld[gi]),
            .tready(rdy[gi]),
            .tdata (dat[gi]),
            .tx    (tx_line[gi]),
            .busy  (bsy[gi])
         );
      end
   endgenerate

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Reference framing: returns the number of bits; w[i] is bit i on the line.
   function automatic int frame_bits(input int d, input logic [7:0] b, output logic [11:0] w);
      int n = 0;
      w = '0;
      w[n] = 1'b0; n++;
      for (int i = 0; i < 8; i++) begin
         w[n] = b[i]; n++;
      end
      if (PAR[d] != 0) begin
         // even: total ones incl. parity is even; odd: total is odd
         w[n] = (($countones(b) % 2) == 1) ^ (PAR[d] == 2); n++;
      end
      for (int s = 0; s < STOP[d]; s++) begin
         w[n] = 1'b1; n++;
      end
      return n;
   endfunction

   function automatic int bound_of(input int d);
      return 14 * CPB[d] + 10;
   endfunction

   // Sends stim[0..n-1]; with hold=1 tvalid stays high between bytes.
   task automatic drive(input int d, input int n, input bit hold);
      int guard;
      for (int k = 0; k < n; k++) begin
         if (!hold && k > 0) begin
            vld[d] = 1'b0;
            repeat ($urandom_range(0, 3 * CPB[d])) @(negedge clk);
         end
         guard  = 0;
         vld[d] = 1'b1;
         while (!rdy[d] && guard < bound_of(d)) begin
            dat[d] = 8'($urandom);
            @(negedge clk);
            guard++;
         end
         dat[d] = stim[k];
         if (!rdy[d]) begin
            check("accept_timeout", {31'd0, rdy[d]}, 32'd1);
            vld[d] = 1'b0;
            return;
         end
         @(negedge clk);
      end
      vld[d] = 1'b0;
   endtask

   // Waits for a start bit, then checks every cycle of the frame.
   task automatic check_frame(input int d, input logic [7:0] b, output int gap);
      logic [11:0] exp_w, obs_w;
      int n, glitches, waited;
      n        = frame_bits(d, b, exp_w);
      obs_w    = '0;
      glitches = 0;
      waited   = 0;
      while (tx_line[d] !== 1'b0 && waited < bound_of(d)) begin
         @(negedge clk);
         waited++;
      end
      gap = waited;
      if (tx_line[d] !== 1'b0) begin
         check("start_timeout", {31'd0, tx_line[d]}, 32'd0);
         return;
      end
      for (int i = 0; i < n; i++) begin
         for (int c = 0; c < CPB[d]; c++) begin
            if (tx_line[d] !== exp_w[i]) glitches++;
            if (c == CPB[d] / 2) obs_w[i] = tx_line[d];
            @(negedge clk);
         end
      end
      $display("dut%0d frame byte=0x%02h bits=%0d obs=0x%03h exp=0x%03h gap=%0d", d, b, n, obs_w, exp_w, gap);
      check("frame_bits", {20'd0, obs_w}, {20'd0, exp_w});
      check("bit_width", glitches, 0);
   endtask

   // Counts low samples on one line over a window.
   task automatic count_lows(input int d, input int cycles, output int lows);
      lows = 0;
      for (int c = 0; c < cycles; c++) begin
         if (tx_line[d] !== 1'b1) lows++;
         @(negedge clk);
      end
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int gap, gap2, lows, w;
      rst = 1'b1;
      vld = '0;
      for (int i = 0; i < NDUT; i++) dat[i] = 8'h00;

      // ---- reset state ----
      repeat (5) @(negedge clk);
      check("rst_tx", tx_line, 4'hF);
      check("rst_busy", bsy, 4'h0);
      check("rst_tready", rdy, 4'h0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_tready", rdy, 4'hF);
      check("post_rst_tx", tx_line, 4'hF);
      repeat (10) @(negedge clk);
      check("idle_tx", tx_line, 4'hF);
      check("idle_busy", bsy, 4'h0);

      // ---- start-bit latency on dut1: accepted at edge N, low from N+2 ----
      vld[1] = 1'b1;
      dat[1] = 8'h4D;
      @(negedge clk);
      vld[1] = 1'b0;
      check("lat_n_tx", tx_line[1], 1'b1);
      check("lat_n_busy", bsy[1], 1'b1);
      @(negedge clk);
      check("lat_n1_tx", tx_line[1], 1'b1);
      @(negedge clk);
      check("lat_n2_tx", tx_line[1], 1'b0);
      repeat (14 * CPB[1]) @(negedge clk);
      check("lat_done_busy", bsy[1], 1'b0);

      // ---- single 0x4D on dut0 ----
      stim[0] = 8'h4D;
      fork
         drive(0, 1, 1'b1);
         check_frame(0, 8'h4D, gap);
      join
      repeat (CPB[0]) @(negedge clk);
      check("single_busy", bsy[0], 1'b0);
      check("single_tready", rdy[0], 1'b1);

      // ---- back-to-back 0x4D, 0xA5 on dut0 with tvalid held ----
      stim[0] = 8'h4D;
      stim[1] = 8'hA5;
      fork
         begin
            drive(0, 2, 1'b1);
            check("b2b_tready_drop", rdy[0], 1'b0);
         end
         begin
            check_frame(0, 8'h4D, gap);
            check_frame(0, 8'hA5, gap2);
            check("b2b_gap", gap2, 0);
         end
      join

      // ---- parity variants with 0x4D ----
      for (int d = 1; d <= 2; d++) begin
         stim[0] = 8'h4D;
         fork
            drive(d, 1, 1'b1);
            check_frame(d, 8'h4D, gap);
         join
      end

      // ---- reset during data bit 3 on dut0 ----
      stim[0] = 8'h4D;
      drive(0, 1, 1'b1);
      w = 0;
      while (tx_line[0] !== 1'b0 && w < bound_of(0)) begin
         @(negedge clk);
         w++;
      end
      repeat (4 * CPB[0] + 200) @(negedge clk);
      check("pre_rst_bit3", tx_line[0], 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_tx", tx_line[0], 1'b1);
      check("midrst_busy", bsy[0], 1'b0);
      count_lows(0, 20 * CPB[0], lows);
      check("midrst_quiet", lows, 0);

      // ---- rst and tvalid in the same cycle: no transfer ----
      rst    = 1'b1;
      vld[1] = 1'b1;
      dat[1] = 8'h33;
      #1;
      check("rstv_tready", rdy[1], 1'b0);
      @(negedge clk);
      rst    = 1'b0;
      vld[1] = 1'b0;
      check("rstv_busy", bsy[1], 1'b0);
      count_lows(1, 3 * CPB[1], lows);
      check("rstv_quiet", lows, 0);

      // ---- randomized streams on the fast instances ----
      for (int d = 1; d < NDUT; d++) begin
         for (int k = 0; k < 5; k++) stim[k] = 8'($urandom);
         fork
            drive(d, 5, d != 3);
            begin
               for (int k = 0; k < 5; k++) begin
                  check_frame(d, stim[k], gap);
                  if (d != 3 && k > 0) check("rand_gap", gap, 0);
               end
            end
         join
         repeat (2 * CPB[d]) @(negedge clk);
         check("rand_idle_busy", bsy[d], 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
